// File: rtl/mdu_pkg.sv
// +--------------------------------------------------------------------------+
// | Module : mdu_pkg                                                         |
// | Desc   : MDU opcodes, FSM states and counter sizing shared by the E-stage |
// |          MDU, the D-stage decoder and the stall unit.                     |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package mdu_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MTHI  = 4'd5,
    MTLO  = 4'd6,
    MADD  = 4'd7,
    MADDU = 4'd8,
    MSUB  = 4'd9,
    MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned c_mult_cycles = 5;
  localparam int unsigned c_div_cycles  = 10;

  // Counter must hold the longest busy period, loaded as-is.
  function automatic int unsigned cnt_width(input int unsigned mult_c,
                                            input int unsigned div_c);
    return $clog2(((mult_c > div_c) ? mult_c : div_c) + 1);
  endfunction

  localparam int unsigned c_cnt_w = cnt_width(c_mult_cycles, c_div_cycles);

endpackage

`default_nettype wire

// File: rtl/e_mdu_if.sv
// +--------------------------------------------------------------------------+
// | Module : e_mdu_if                                                        |
// | Desc   : E-stage issue / HI-LO read bundle between the pipeline and MDU. |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface e_mdu_if;
  import mdu_pkg::*;

  logic        start;
  mdu_op_e     op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hi;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, op, a, b, rd_hi,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  start, op, a, b, rd_hi,
    output busy, hi, lo, rd_data
  );

endinterface

`default_nettype wire

// File: rtl/mdu_arith.sv
// +--------------------------------------------------------------------------+
// | Module : mdu_arith                                                       |
// | Desc   : Combinational 64-bit {HI,LO} result for mult/div (and the       |
// |          accumulate ops when MDU_MADD_EN is defined), plus a div0 flag.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
`ifdef MDU_MADD_EN
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
`endif
  output logic [63:0] o_res,
  output logic        o_div0
);

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic signed [32:0] w_sa;
  logic signed [32:0] w_sb;
  logic        [31:0] w_q_s;
  logic        [31:0] w_r_s;
  logic        [31:0] w_q_u;
  logic        [31:0] w_r_u;
  logic               w_div0;

  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // 33-bit signed operands so 0x80000000 / -1 yields +2^31 before truncation.
  assign w_sa   = {i_a[31], i_a};
  assign w_sb   = {i_b[31], i_b};
  assign w_div0 = (i_b == 32'd0);
  assign o_div0 = w_div0;

  always_comb begin
    w_q_s = '0;
    w_r_s = '0;
    w_q_u = '0;
    w_r_u = '0;
    if (!w_div0) begin
      w_q_s = 32'(w_sa / w_sb);
      w_r_s = 32'(w_sa % w_sb);
      w_q_u = i_a / i_b;
      w_r_u = i_a % i_b;
    end
  end

`ifdef MDU_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = {i_hi, i_lo};
`endif

  always_comb begin
    o_res = '0;
    case (i_op)
      MULT:  o_res = w_prod_s;
      MULTU: o_res = w_prod_u;
      DIV:   o_res = {w_r_s, w_q_s};
      DIVU:  o_res = {w_r_u, w_q_u};
`ifdef MDU_MADD_EN
      MADD:  o_res = w_acc + w_prod_s;
      MADDU: o_res = w_acc + w_prod_u;
      MSUB:  o_res = w_acc - w_prod_s;
      MSUBU: o_res = w_acc - w_prod_u;
`endif
      default: o_res = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/e_mdu.sv
// +--------------------------------------------------------------------------+
// | Module : e_mdu                                                           |
// | Desc   : E-stage multi-cycle multiply/divide unit owning HI/LO and BUSY. |
// |          MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulate ops.       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module e_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = c_mult_cycles,
  parameter int unsigned DIV_CYCLES  = c_div_cycles
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave bus
);

  localparam int unsigned c_cnt_w = cnt_width(MULT_CYCLES, DIV_CYCLES);

  mdu_state_e         r_state,   w_state_nx;
  logic [c_cnt_w-1:0] r_cnt,     w_cnt_nx;
  logic [31:0]        r_hi,      w_hi_nx;
  logic [31:0]        r_lo,      w_lo_nx;
  logic [31:0]        r_pend_hi, w_pend_hi_nx;
  logic [31:0]        r_pend_lo, w_pend_lo_nx;
  logic               r_pend_wr, w_pend_wr_nx;
  logic [63:0]        w_res;
  logic               w_div0;

  mdu_arith u_arith (
    .i_op   (bus.op),
    .i_a    (bus.a),
    .i_b    (bus.b),
`ifdef MDU_MADD_EN
    .i_hi   (r_hi),
    .i_lo   (r_lo),
`endif
    .o_res  (w_res),
    .o_div0 (w_div0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_hi      <= w_hi_nx;
      r_lo      <= w_lo_nx;
      r_pend_hi <= w_pend_hi_nx;
      r_pend_lo <= w_pend_lo_nx;
      r_pend_wr <= w_pend_wr_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_hi_nx      = r_hi;
    w_lo_nx      = r_lo;
    w_pend_hi_nx = r_pend_hi;
    w_pend_lo_nx = r_pend_lo;
    w_pend_wr_nx = r_pend_wr;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            MULT, MULTU
`ifdef MDU_MADD_EN
            , MADD, MADDU, MSUB, MSUBU
`endif
            : begin
              w_state_nx   = S_BUSY;
              w_cnt_nx     = c_cnt_w'(MULT_CYCLES);
              w_pend_hi_nx = w_res[63:32];
              w_pend_lo_nx = w_res[31:0];
              w_pend_wr_nx = 1'b1;
            end
            DIV, DIVU: begin
              // Divide by zero still burns the full period but writes nothing.
              w_state_nx   = S_BUSY;
              w_cnt_nx     = c_cnt_w'(DIV_CYCLES);
              w_pend_hi_nx = w_res[63:32];
              w_pend_lo_nx = w_res[31:0];
              w_pend_wr_nx = !w_div0;
            end
            MTHI:    w_hi_nx = bus.a;
            MTLO:    w_lo_nx = bus.a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        w_cnt_nx = r_cnt - c_cnt_w'(1);
        if (r_cnt == c_cnt_w'(1)) begin
          w_state_nx = S_IDLE;
          if (r_pend_wr) begin
            w_hi_nx = r_pend_hi;
            w_lo_nx = r_pend_lo;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign bus.busy    = (r_state == S_BUSY);
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.rd_data = bus.rd_hi ? r_hi : r_lo;

endmodule

`default_nettype wire
